// File: rtl/bcd_field_scheduler_pkg.sv
// Shared types and constants for the time-sharing BCD field scheduler.
// Field order is the order fields are fed to the external converter.
package bcd_field_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_GAP     = 3'd0,
        ST_SNAP    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_WAIT    = 3'd3,
        ST_STORE   = 3'd4,
        ST_PUBLISH = 3'd5
    } sched_state_e;

    typedef logic [2:0] fld_idx_t;

    localparam fld_idx_t FLD_SEC  = 3'd0;
    localparam fld_idx_t FLD_MIN  = 3'd1;
    localparam fld_idx_t FLD_HOUR = 3'd2;
    localparam fld_idx_t FLD_DAY  = 3'd3;
    localparam fld_idx_t FLD_MON  = 3'd4;
    localparam fld_idx_t FLD_YEAR = 3'd5;

    localparam logic [3:0] ERR_DIGIT = 4'hF;

    // Element 0 holds the second, element 5 the year.
    typedef logic [5:0][7:0] snap_t;

    typedef struct packed {
        logic [3:0] hun_year;
        logic [3:0] ten_year;
        logic [3:0] one_year;
        logic [3:0] ten_mon;
        logic [3:0] one_mon;
        logic [3:0] ten_day;
        logic [3:0] one_day;
        logic [3:0] ten_hour;
        logic [3:0] one_hour;
        logic [3:0] ten_min;
        logic [3:0] one_min;
        logic [3:0] ten_sec;
        logic [3:0] one_sec;
    } bcd_frame_t;

    function automatic logic [7:0] field_of(input snap_t s, input fld_idx_t i);
        logic [7:0] r;
        case (i)
            FLD_SEC:  r = s[0];
            FLD_MIN:  r = s[1];
            FLD_HOUR: r = s[2];
            FLD_DAY:  r = s[3];
            FLD_MON:  r = s[4];
            FLD_YEAR: r = s[5];
            default:  r = 8'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bcd_field_scheduler_if.sv
// Handshake between the scheduler (master) and the shared bin2bcd converter (slave).
interface bcd_field_scheduler_if;
    import bcd_field_scheduler_pkg::*;

    logic       conv_start;
    logic [7:0] conv_bin;
    logic       conv_done;
    logic [3:0] conv_hun;
    logic [3:0] conv_ten;
    logic [3:0] conv_one;

    modport master (
        output conv_start, conv_bin,
        input  conv_done, conv_hun, conv_ten, conv_one
    );

    modport slave (
        input  conv_start, conv_bin,
        output conv_done, conv_hun, conv_ten, conv_one
    );

endinterface

// File: rtl/bcd_field_scheduler_shadow_bank.sv
// Shadow digit registers filled one field at a time, copied to the visible
// frame only on publish so the outputs never show a partly updated sweep.
module bcd_shadow_bank
    import bcd_field_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  fld_idx_t   wr_idx,
    input  logic [3:0] wr_hun,
    input  logic [3:0] wr_ten,
    input  logic [3:0] wr_one,
    input  logic       pub_en,
    output bcd_frame_t frame
);

    bcd_frame_t shadow_q, shadow_d;
    bcd_frame_t frame_q, frame_d;

    // Next shadow/frame contents: indexed field write, whole-frame publish copy.
    always_comb begin
        shadow_d = shadow_q;
        frame_d  = frame_q;
        if (wr_en) begin
            case (wr_idx)
                FLD_SEC: begin
                    shadow_d.ten_sec = wr_ten;
                    shadow_d.one_sec = wr_one;
                end
                FLD_MIN: begin
                    shadow_d.ten_min = wr_ten;
                    shadow_d.one_min = wr_one;
                end
                FLD_HOUR: begin
                    shadow_d.ten_hour = wr_ten;
                    shadow_d.one_hour = wr_one;
                end
                FLD_DAY: begin
                    shadow_d.ten_day = wr_ten;
                    shadow_d.one_day = wr_one;
                end
                FLD_MON: begin
                    shadow_d.ten_mon = wr_ten;
                    shadow_d.one_mon = wr_one;
                end
                FLD_YEAR: begin
                    shadow_d.hun_year = wr_hun;
                    shadow_d.ten_year = wr_ten;
                    shadow_d.one_year = wr_one;
                end
                default: begin
                    shadow_d = shadow_q;
                end
            endcase
        end else begin
            shadow_d = shadow_q;
        end
        if (pub_en) begin
            frame_d = shadow_q;
        end else begin
            frame_d = frame_q;
        end
    end

    // Shadow and published frame registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q <= '0;
            frame_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
        end
    end

    assign frame = frame_q;

endmodule

// File: rtl/bcd_field_scheduler.sv
// Time-shares one external binary-to-BCD converter across the six time/date
// fields and publishes a coherent 13-digit frame after each sweep.
module bcd_field_scheduler
    import bcd_field_scheduler_pkg::*;
#(
    parameter int TIMEOUT  = 16,
    parameter int SCAN_GAP = 64
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        force_scan,
    input  logic [7:0]  year,
    input  logic [7:0]  month,
    input  logic [7:0]  day,
    input  logic [7:0]  hour,
    input  logic [7:0]  minute,
    input  logic [7:0]  second,
    bcd_field_scheduler_if.master conv,
    output logic [3:0]  hunYear,
    output logic [3:0]  tenYear,
    output logic [3:0]  oneYear,
    output logic [3:0]  tenMonth,
    output logic [3:0]  oneMonth,
    output logic [3:0]  tenDay,
    output logic [3:0]  oneDay,
    output logic [3:0]  tenHour,
    output logic [3:0]  oneHour,
    output logic [3:0]  tenMinute,
    output logic [3:0]  oneMinute,
    output logic [3:0]  tenSecond,
    output logic [3:0]  oneSecond,
    output logic        frame_valid,
    output logic        busy,
    output logic        err
);

    localparam int GAP_W = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
    localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    sched_state_e     state_q, state_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    fld_idx_t         idx_q, idx_d;
    snap_t            snap_q, snap_d;
    logic             conv_start_q, conv_start_d;
    logic [7:0]       conv_bin_q, conv_bin_d;
    logic             busy_q, busy_d;
    logic             frame_valid_q, frame_valid_d;
    logic             err_q, err_d;

    logic             wr_en_s;
    logic [3:0]       wr_hun_s;
    logic [3:0]       wr_ten_s;
    logic [3:0]       wr_one_s;
    logic             pub_en_s;
    bcd_frame_t       frame_s;

    // Next-state and registered-output logic of the sweep sequencer.
    always_comb begin
        state_d       = state_q;
        gap_cnt_d     = gap_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        idx_d         = idx_q;
        snap_d        = snap_q;
        conv_start_d  = 1'b0;
        conv_bin_d    = conv_bin_q;
        busy_d        = busy_q;
        frame_valid_d = 1'b0;
        err_d         = err_q;
        wr_en_s       = 1'b0;
        wr_hun_s      = conv.conv_hun;
        wr_ten_s      = conv.conv_ten;
        wr_one_s      = conv.conv_one;
        pub_en_s      = 1'b0;

        case (state_q)
            ST_GAP: begin
                if (force_scan || (gap_cnt_q == GAP_LAST)) begin
                    state_d   = ST_SNAP;
                    gap_cnt_d = '0;
                    busy_d    = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            ST_SNAP: begin
                snap_d       = {year, month, day, hour, minute, second};
                idx_d        = FLD_SEC;
                conv_bin_d   = second;
                conv_start_d = 1'b1;
                state_d      = ST_ISSUE;
            end
            ST_ISSUE: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                // The converter result is only valid in the done cycle, so it
                // goes straight into the shadow bank here.
                if (conv.conv_done) begin
                    wr_en_s = 1'b1;
                    state_d = ST_STORE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    wr_en_s  = 1'b1;
                    wr_hun_s = ERR_DIGIT;
                    wr_ten_s = ERR_DIGIT;
                    wr_one_s = ERR_DIGIT;
                    err_d    = 1'b1;
                    state_d  = ST_STORE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
            end
            ST_STORE: begin
                if (idx_q == FLD_YEAR) begin
                    pub_en_s      = 1'b1;
                    frame_valid_d = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = ST_PUBLISH;
                end else begin
                    idx_d        = idx_q + 3'd1;
                    conv_bin_d   = field_of(snap_q, idx_q + 3'd1);
                    conv_start_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_PUBLISH: begin
                gap_cnt_d = '0;
                state_d   = ST_GAP;
            end
            default: begin
                state_d   = ST_GAP;
                gap_cnt_d = '0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Sequencer state, counters, snapshot and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_GAP;
            gap_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            idx_q         <= FLD_SEC;
            snap_q        <= '0;
            conv_start_q  <= 1'b0;
            conv_bin_q    <= 8'd0;
            busy_q        <= 1'b0;
            frame_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            gap_cnt_q     <= gap_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            idx_q         <= idx_d;
            snap_q        <= snap_d;
            conv_start_q  <= conv_start_d;
            conv_bin_q    <= conv_bin_d;
            busy_q        <= busy_d;
            frame_valid_q <= frame_valid_d;
            err_q         <= err_d;
        end
    end

    bcd_shadow_bank u_shadow_bank (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en_s),
        .wr_idx (idx_q),
        .wr_hun (wr_hun_s),
        .wr_ten (wr_ten_s),
        .wr_one (wr_one_s),
        .pub_en (pub_en_s),
        .frame  (frame_s)
    );

    assign conv.conv_start = conv_start_q;
    assign conv.conv_bin   = conv_bin_q;

    assign hunYear   = frame_s.hun_year;
    assign tenYear   = frame_s.ten_year;
    assign oneYear   = frame_s.one_year;
    assign tenMonth  = frame_s.ten_mon;
    assign oneMonth  = frame_s.one_mon;
    assign tenDay    = frame_s.ten_day;
    assign oneDay    = frame_s.one_day;
    assign tenHour   = frame_s.ten_hour;
    assign oneHour   = frame_s.one_hour;
    assign tenMinute = frame_s.ten_min;
    assign oneMinute = frame_s.one_min;
    assign tenSecond = frame_s.ten_sec;
    assign oneSecond = frame_s.one_sec;

    assign frame_valid = frame_valid_q;
    assign busy        = busy_q;
    assign err         = err_q;

endmodule
